// File: rtl/mem_lsu.sv
// Load/store initiator for one port of a byte-addressed memory.
// Unaligned requests are split into one or two word-aligned accesses.
`timescale 1ns/1ps
module mem_lsu #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_start,
  output logic [31:0] mem_write,
  input  logic [31:0] mem_read
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC0 = 2'd1;
  localparam logic [1:0] S_ACC1 = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, signed_q, split_q, err_q;
  logic [1:0]  size_q, off_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q, lo_q, hi_q;

  logic        accept;
  logic [2:0]  req_nbytes;
  logic [32:0] req_last;
  logic        req_err, req_split;

  always_comb begin
    unique case (req_size)
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
  end

  // 33-bit arithmetic so an address wrap past 2^32 reports as out of range
  assign req_last  = {1'b0, req_addr} + {30'b0, req_nbytes} - 33'd1;
  assign req_err   = (req_size == 2'b11) || (req_last >= 33'(MEM_BYTES));
  assign req_split = ({1'b0, req_addr[1:0]} + req_nbytes) > 3'd4;
  assign accept    = req_valid && req_ready;

  logic [3:0]  lane_mask;
  logic [7:0]  lane_wide;
  logic [63:0] wdata_wide;
  logic [31:0] rd_word, load_val;

  always_comb begin
    unique case (size_q)
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Upper halves of the widened shifts feed the second (ACC1) access
  assign lane_wide  = {4'b0, lane_mask} << off_q;
  assign wdata_wide = {32'b0, wdata_q} << {off_q, 3'b000};
  assign rd_word    = 32'({hi_q, lo_q} >> {off_q, 3'b000});

  always_comb begin
    unique case (size_q)
      2'b00:   load_val = {{24{signed_q & rd_word[7]}}, rd_word[7:0]};
      2'b01:   load_val = {{16{signed_q & rd_word[15]}}, rd_word[15:0]};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = req_err ? S_RESP : S_ACC0;
      S_ACC0: state_d = split_q ? S_ACC1 : S_RESP;
      S_ACC1: state_d = S_RESP;
      default: if (rsp_ready) state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_start = '0;
    mem_write = '0;
    if (state_q == S_ACC0) begin
      mem_addr = {word_q, 2'b00};
      if (we_q) begin
        mem_start = lane_wide[3:0];
        mem_write = wdata_wide[31:0];
      end
    end else if (state_q == S_ACC1) begin
      mem_addr = {word_q + 30'd1, 2'b00};
      if (we_q) begin
        mem_start = lane_wide[7:4];
        mem_write = wdata_wide[63:32];
      end
    end
  end

  assign req_ready = rst_n && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) && err_q;
  assign rsp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ? load_val : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      off_q    <= 2'b00;
      word_q   <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        split_q  <= req_split;
        err_q    <= req_err;
        size_q   <= req_size;
        off_q    <= req_addr[1:0];
        word_q   <= req_addr[31:2];
        wdata_q  <= req_wdata;
        lo_q     <= '0;
        hi_q     <= '0;
      end
      if ((state_q == S_ACC0) && !we_q) lo_q <= mem_read;
      if ((state_q == S_ACC1) && !we_q) hi_q <= mem_read;
    end
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store initiator that drives one port of the byte-addressed dual-port memory on behalf of the pipeline's memory stage. It accepts byte, half and word load/store requests at any alignment and issues only word-aligned memory accesses. Each request becomes one aligned access, or two when it crosses a word boundary. The unit merges or shifts data, sign- or zero-extends loads, and returns one response per request through a valid/ready handshake.

Parameters:
MEM_BYTES, 1024, size of the addressable memory in bytes; any request touching a byte at or above this address is an error.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  load sign-extension enable; ignored for stores
req_addr  in  32  byte address, any alignment
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_err  out  1  illegal size or out-of-range access
mem_addr  out  32  word-aligned memory address (bits[1:0] always 00)
mem_start  out  4  per-byte write enable, lane k = bits [8k+7:8k]
mem_write  out  32  memory write data, lane-positioned
mem_read  in  32  combinational memory read data at mem_addr

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - req_ready=1 once released; all other outputs 0, including mem_start=0000 and mem_addr=0.
- Reset mid-operation:
  - The request is abandoned and no response is produced.
  - If a split store had completed ACC0, those bytes stay written.
- Derived values, latched at acceptance:
  - nbytes=1/2/4 from size; off=addr[1:0]; base={addr[31:2],00}.
  - split = (off+nbytes>4).
  - err = (size==11) OR (addr+nbytes-1 >= MEM_BYTES), computed in 33 bits so overflow counts as error.
- States:
  - IDLE -> ACC0 on req_valid&&req_ready; all request fields are latched.
  - If err, IDLE -> RESP directly; mem_start stays 0000 for the whole request.
  - ACC0: mem_addr=base. Store: mem_start=lanemask<<off (low 4 bits), mem_write=wdata<<(8*off). Load: capture mem_read into lo. Next state ACC1 if split, else RESP.
  - ACC1: mem_addr=base+4 (wraps mod 2^32). Store: mem_start=lanemask>>(4-off), mem_write=wdata>>(8*(4-off)). Load: capture mem_read into hi. Next state RESP.
  - RESP: rsp_valid=1 and rsp_rdata/rsp_err stable until rsp_ready=1, then IDLE. No new request is accepted in the same cycle.
- mem_start is 0000 outside ACC0/ACC1 and always 0000 for loads; mem_write=0 when mem_start=0.
- Load result:
  - ({hi,lo} >> 8*off) truncated to nbytes.
  - Sign-extended from its top bit if req_signed, else zero-extended.
  - hi=0 when not split.
- Latency (accept edge = cycle 0): unsplit rsp_valid in cycle 2; split in cycle 3; error in cycle 1.
- Throughput: one request in flight; req_ready=0 in ACC0/ACC1/RESP.

Test Plan:
1. Word store 0xDEADBEEF @0x100 -> ACC0 mem_addr=0x100, mem_start=1111, mem_write=0xDEADBEEF; rsp_valid cycle 2, rsp_err=0, rsp_rdata=0.
2. Byte load @0x103, memory word 0x80000000: signed -> rsp_rdata=0xFFFFFF80; unsigned -> 0x00000080; mem_start=0000 throughout.
3. Word store 0x11223344 @0x0FE -> ACC0 addr 0x0FC, start 1100, write 0x33440000; ACC1 addr 0x100, start 0011, write 0x00001122; rsp cycle 3.
4. Half load signed @0x203, mem[0x203]=0x34, mem[0x204]=0x92 -> two accesses (0x200, 0x204); rsp_rdata=0xFFFF9234; unsigned gives 0x00009234.
5. Word @0x3FE (MEM_BYTES=1024) -> rsp_err=1 cycle 1, mem_start never nonzero. size=11 @0x0 -> rsp_err=1. Byte @0x3FF -> rsp_err=0.
6. rsp_ready low 3 cycles -> rsp_valid/rdata held and req_ready=0. Separately, rst_n low during ACC1 of a split store -> outputs 0 at once, no response, only ACC0 bytes written.
